// File: rtl/round_robin_arbiter_4_if.sv
// Bus between requesters and the 4-way round-robin arbiter.
// Handshake: req[i] is a level held high while requester i needs the resource; gnt[i] high means i owns it this cycle.
interface round_robin_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       preempt;
  logic [1:0] dbg_state;

  modport master (
    output en, req,
    input  gnt, gnt_idx, busy, preempt, dbg_state
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, busy, preempt, dbg_state
  );
endinterface

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure (HOLD_MAX) and a one-cycle
// turnaround gap after every grant.
module round_robin_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  round_robin_arbiter_4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] idx_q;
  logic [7:0] cnt_q;
  logic [3:0] gnt_q;
  logic       pre_q;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Walk from the farthest offset down so the one closest to ptr_q is kept.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      pre_q   <= 1'b0;
    end else begin
      pre_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (bus.en && win_valid) begin
            state_q <= GRANT;
            idx_q   <= win_idx;
            cnt_q   <= 8'd0;
            gnt_q   <= 4'b0001 << win_idx;
          end else begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
          end
        end
        GRANT: begin
          // Release wins over a simultaneous timeout, so no preempt pulse then.
          if (!bus.req[idx_q] || !bus.en) begin
            state_q <= GAP;
            gnt_q   <= 4'b0000;
            ptr_q   <= idx_q + 2'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= GAP;
            gnt_q   <= 4'b0000;
            ptr_q   <= idx_q + 2'd1;
            pre_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.preempt   = pre_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4: two instances (HOLD_MAX=4 and HOLD_MAX=1) share stimulus
// and are checked every cycle against an ownership-level model plus literal expectations.
module tb_round_robin_arbiter_4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic       chk_on;

  int pass_cnt  = 0;
  int total_cnt = 0;

  round_robin_arbiter_4_if if_a ();
  round_robin_arbiter_4_if if_b ();

  assign if_a.en  = en;
  assign if_a.req = req;
  assign if_b.en  = en;
  assign if_b.req = req;

  round_robin_arbiter_4 #(.HOLD_MAX(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  round_robin_arbiter_4 #(.HOLD_MAX(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: who owns the resource, for how many cycles, and where the search starts next
  int m_owner [2] = '{-1, -1};
  int m_held  [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};
  int m_idx   [2] = '{0, 0};
  bit m_gap   [2] = '{0, 0};
  bit m_pre   [2] = '{0, 0};
  int hold_of [2] = '{4, 1};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_owner[k] = -1; m_held[k] = 0; m_ptr[k] = 0;
        m_idx[k] = 0; m_gap[k] = 0; m_pre[k] = 0;
      end else if (m_owner[k] >= 0) begin
        if (!req[m_owner[k]] || !en) begin
          m_ptr[k] = (m_owner[k] + 1) % 4; m_owner[k] = -1; m_gap[k] = 1; m_pre[k] = 0;
        end else if (m_held[k] == hold_of[k]) begin
          m_ptr[k] = (m_owner[k] + 1) % 4; m_owner[k] = -1; m_gap[k] = 1; m_pre[k] = 1;
        end else begin
          m_held[k] = m_held[k] + 1;
        end
      end else begin
        m_pre[k] = 0;
        m_gap[k] = 0;
        if (en) begin
          for (int j = 0; j < 4; j++) begin
            if (m_owner[k] < 0 && req[(m_ptr[k] + j) % 4]) begin
              m_owner[k] = (m_ptr[k] + j) % 4;
              m_idx[k]   = m_owner[k];
              m_held[k]  = 1;
            end
          end
        end
      end
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic cmp(input int k, input logic [3:0] g, input logic [1:0] gi,
                     input logic b, input logic p);
    logic [3:0] eg;
    eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
    check($sformatf("model_gnt[%0d]", k), 8'(g), 8'(eg));
    check($sformatf("model_idx[%0d]", k), 8'(gi), 8'(m_idx[k]));
    check($sformatf("model_busy[%0d]", k), 8'(b), 8'(m_owner[k] >= 0 || m_gap[k]));
    check($sformatf("model_pre[%0d]", k), 8'(p), 8'(m_pre[k]));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, if_a.gnt, if_a.gnt_idx, if_a.busy, if_a.preempt);
      cmp(1, if_b.gnt, if_b.gnt_idx, if_b.busy, if_b.preempt);
    end
  end

  // directed vectors for the free-running phase: reset, en, req, cycles
  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] req;
    int         len;
  } vec_t;

  vec_t tbl [12] = '{
    '{1'b1, 1'b1, 4'b0000, 1},
    '{1'b0, 1'b1, 4'b1001, 7},
    '{1'b0, 1'b1, 4'b0110, 6},
    '{1'b0, 1'b0, 4'b0110, 3},
    '{1'b0, 1'b1, 4'b1111, 12},
    '{1'b0, 1'b1, 4'b0010, 9},
    '{1'b0, 1'b1, 4'b1000, 2},
    '{1'b0, 1'b1, 4'b0101, 11},
    '{1'b1, 1'b1, 4'b0101, 1},
    '{1'b0, 1'b1, 4'b1110, 8},
    '{1'b0, 1'b1, 4'b0000, 3},
    '{1'b0, 1'b1, 4'b1011, 10}
  };

  // driver
  initial begin
    chk_on = 1'b0;
    en     = 1'b0;
    req    = 4'b0000;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 8'(if_a.gnt), 8'h00);
    check("rst_idx", 8'(if_a.gnt_idx), 8'h00);
    check("rst_busy", 8'(if_a.busy), 8'h00);
    check("rst_pre", 8'(if_a.preempt), 8'h00);

    // single request then release
    chk_on = 1'b1;
    reset = 1'b0; en = 1'b1; req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 8'(if_a.gnt), 8'h04);
    check("single_idx", 8'(if_a.gnt_idx), 8'h02);
    check("single_busy", 8'(if_a.busy), 8'h01);
    req = 4'b0000;
    @(negedge clk);
    check("single_gap_gnt", 8'(if_a.gnt), 8'h00);
    check("single_gap_busy", 8'(if_a.busy), 8'h01);
    check("single_gap_pre", 8'(if_a.preempt), 8'h00);
    @(negedge clk);
    check("single_idle_busy", 8'(if_a.busy), 8'h00);
    check("single_idle_idx", 8'(if_a.gnt_idx), 8'h02);

    // all requesting, HOLD_MAX=4 rotation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("rot_gnt_r%0d_c%0d", r, c), 8'(if_a.gnt), 8'(4'b0001 << r));
        check($sformatf("rot_pre_r%0d_c%0d", r, c), 8'(if_a.preempt), 8'h00);
      end
      @(negedge clk);
      check($sformatf("rot_gap_gnt_r%0d", r), 8'(if_a.gnt), 8'h00);
      check($sformatf("rot_gap_pre_r%0d", r), 8'(if_a.preempt), 8'h01);
    end
    @(negedge clk);
    check("rot_wrap_gnt", 8'(if_a.gnt), 8'h01);

    // reset during an active grant
    reset = 1'b1;
    @(negedge clk);
    check("midrst_gnt", 8'(if_a.gnt), 8'h00);
    check("midrst_idx", 8'(if_a.gnt_idx), 8'h00);
    check("midrst_busy", 8'(if_a.busy), 8'h00);
    check("midrst_pre", 8'(if_a.preempt), 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_regnt", 8'(if_a.gnt), 8'h01);

    // release of requester 1, pointer skips to 3
    reset = 1'b1; req = 4'b0000;
    @(negedge clk);
    reset = 1'b0; req = 4'b1010;
    @(negedge clk);
    check("rel_gnt_c0", 8'(if_a.gnt), 8'h02);
    @(negedge clk);
    check("rel_gnt_c1", 8'(if_a.gnt), 8'h02);
    req = 4'b1000;
    @(negedge clk);
    check("rel_gap_gnt", 8'(if_a.gnt), 8'h00);
    check("rel_gap_pre", 8'(if_a.preempt), 8'h00);
    check("rel_gap_busy", 8'(if_a.busy), 8'h01);
    req = 4'b1010;
    @(negedge clk);
    check("rel_next_gnt", 8'(if_a.gnt), 8'h08);

    // enable dropped mid-grant
    en = 1'b0;
    @(negedge clk);
    check("en_gap_gnt", 8'(if_a.gnt), 8'h00);
    check("en_gap_busy", 8'(if_a.busy), 8'h01);
    @(negedge clk);
    check("en_idle_busy", 8'(if_a.busy), 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("en_off_gnt", 8'(if_a.gnt), 8'h00);
    end
    en = 1'b1;
    @(negedge clk);
    check("en_resume_gnt", 8'(if_a.gnt), 8'h02);

    // HOLD_MAX=1, lone requester alternates grant/gap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("h1_gnt_%0d", i), 8'(if_b.gnt), 8'h01);
      check($sformatf("h1_pre_%0d", i), 8'(if_b.preempt), 8'h00);
      @(negedge clk);
      check($sformatf("h1_gap_gnt_%0d", i), 8'(if_b.gnt), 8'h00);
      check($sformatf("h1_gap_pre_%0d", i), 8'(if_b.preempt), 8'h01);
    end

    // free-running table, checked by the model only
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      en    = tbl[i].en;
      req   = tbl[i].req;
      repeat (tbl[i].len) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive grant cycles per tenure; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  global arbitration enable; low = no grants issued.
REQ-005 req  input  4  per-requester request, level; held high for as long as the shared resource is needed.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 gnt_idx  output  2  binary index of current/last grantee, registered.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 preempt  output  1  one-cycle pulse marking a grant ended by HOLD_MAX timeout.

Function
REQ-010 States: IDLE, GRANT, GAP; 2-bit encoding; unused encoding returns to IDLE next cycle.
REQ-011 gnt is the 2-to-4 decode of gnt_idx, enabled only in GRANT; gnt = 4'b0000 in IDLE and GAP.
REQ-012 Priority pointer ptr (2 bits): winner = first requester with req high, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-013 IDLE: if en=1 and req!=0, the arbiter loads gnt_idx=winner, clears the hold counter and enters GRANT; otherwise it stays in IDLE.
REQ-014 Latency: req sampled high at edge N (from IDLE) -> gnt valid from edge N onward, i.e. one registered cycle after req is presented.
REQ-015 GRANT: hold counter increments every cycle; grant is kept while req[gnt_idx]=1, en=1 and counter < HOLD_MAX-1.
REQ-016 GRANT exit on req[gnt_idx]=0 (release) or en=0: next state GAP, preempt=0.
REQ-017 GRANT exit on counter = HOLD_MAX-1 with req[gnt_idx] still high: next state GAP, preempt=1 during the GAP cycle; gnt therefore high exactly HOLD_MAX cycles.
REQ-018 On every GRANT exit, ptr = gnt_idx+1 mod 4 (wrap 3 -> 0); gnt_idx holds its value through GAP and IDLE.
REQ-019 GAP lasts exactly one cycle with gnt=0 (bus turnaround); at its end arbitration per REQ-012/013 executes directly: winner -> GRANT, else IDLE.
REQ-020 Release and timeout in the same cycle: treated as release (preempt=0).
REQ-021 A requester preempted with no competitor is regranted after the single GAP cycle.
REQ-022 req changes of non-granted requesters never affect the current grant.
REQ-023 en=0 while IDLE or GAP: no grant; GAP proceeds to IDLE.
REQ-024 HOLD_MAX=1: every grant lasts one cycle, followed by GAP, preempt=1 when req is still held.

Reset
REQ-025 reset=1 at an edge forces state=IDLE, ptr=0, counter=0, gnt=4'b0000, gnt_idx=2'b00, busy=0, preempt=0, overriding all other inputs including an active grant.
REQ-026 First arbitration after reset starts from priority order 0,1,2,3.

Verification
REQ-027 Reset, en=1, req=4'b0100 -> next cycle gnt=4'b0100, gnt_idx=2, busy=1; drop req -> one cycle gnt=0000 (GAP), then IDLE, busy=0.
REQ-028 HOLD_MAX=4, req=4'b1111 held -> gnt 0001 x4, gap, 0010 x4, gap, 0100 x4, gap, 1000 x4, gap, 0001 (wrap); preempt=1 in each gap cycle.
REQ-029 req=4'b1010, grant to 1 released after 2 cycles while req[1] reasserted -> GAP then gnt=1000 (ptr=2 skips to 3), preempt=0.
REQ-030 en driven 0 during GRANT -> gnt=0000 next cycle, no grant while en=0, arbitration resumes the cycle after en=1 at ptr=gnt_idx+1.
REQ-031 reset pulsed during GRANT with req=4'b1111 -> next cycle all outputs zero, then gnt=0001 (ptr back to 0).
REQ-032 HOLD_MAX=1, req=4'b0001 only -> gnt alternates 0001/0000 each cycle, preempt high every GAP cycle.
